// File: rtl/gate_pkg.sv
// Shared encodings for the gate sweep checker and its golden model.
package gate_pkg;

   typedef enum logic [2:0] {
      MODE_AND  = 3'd0,
      MODE_OR   = 3'd1,
      MODE_NAND = 3'd2,
      MODE_NOR  = 3'd3,
      MODE_XOR  = 3'd4,
      MODE_XNOR = 3'd5,
      MODE_NOT  = 3'd6,
      MODE_BUF  = 3'd7
   } gate_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } sweep_state_e;

endpackage

// File: rtl/gate_golden.sv
// Combinational reference output of an N_IN-input gate for the selected mode.
// NOT and BUF look only at bit 0; everything else reduces the whole vector.
module gate_golden
   import gate_pkg::*;
#(
   parameter int N_IN = 2
) (
   input  logic [2:0]      mode,
   input  logic [N_IN-1:0] vec,
   output logic            y
);

   always_comb begin
      y = 1'b0;
      case (mode)
         MODE_AND:  y = &vec;
         MODE_OR:   y = |vec;
         MODE_NAND: y = ~(&vec);
         MODE_NOR:  y = ~(|vec);
         MODE_XOR:  y = ^vec;
         MODE_XNOR: y = ~(^vec);
         MODE_NOT:  y = ~vec[0];
         MODE_BUF:  y = vec[0];
         default:   y = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep of a 1-bit gate: one vector every SETTLE+1 cycles, done 2^N_IN*(SETTLE+1)+1 cycles after start.
// start is only sampled in IDLE and is never queued; results are registered, so dut_in has no path to any output.
module gate_sweep_checker
   import gate_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       mode,
   output logic [N_IN-1:0]  stim_out,
   input  logic             dut_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             first_fail_valid,
   output logic [N_IN-1:0]  first_fail_vec
);

   // One extra stimulus bit lets the terminal vector be recognised without wrapping.
   localparam int SW = N_IN + 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [SW-1:0]    LAST_VEC    = SW'((1 << N_IN) - 1);
   localparam logic [SW-1:0]    STIM_ONE    = SW'(1);
   localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE - 1);
   localparam logic [CW-1:0]    SETTLE_ONE  = CW'(1);
   localparam logic [ERR_W-1:0] ERR_SAT     = '1;
   localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

   sweep_state_e     r_state, w_state_nxt;
   logic [2:0]       r_mode, w_mode_nxt;
   logic [SW-1:0]    r_stim, w_stim_nxt;
   logic [CW-1:0]    r_settle, w_settle_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic             r_pass, w_pass_nxt;
   logic [ERR_W-1:0] r_err, w_err_nxt;
   logic             r_ffv, w_ffv_nxt;
   logic [N_IN-1:0]  r_ffvec, w_ffvec_nxt;

   logic             w_gold;
   logic             w_mismatch;

   gate_golden #(
      .N_IN (N_IN)
   ) u_golden (
      .mode (r_mode),
      .vec  (r_stim[N_IN-1:0]),
      .y    (w_gold)
   );

   assign w_mismatch = dut_in ^ w_gold;

   always_comb begin
      w_state_nxt  = r_state;
      w_mode_nxt   = r_mode;
      w_stim_nxt   = r_stim;
      w_settle_nxt = r_settle;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_pass_nxt   = r_pass;
      w_err_nxt    = r_err;
      w_ffv_nxt    = r_ffv;
      w_ffvec_nxt  = r_ffvec;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_mode_nxt   = mode;
               w_err_nxt    = '0;
               w_ffv_nxt    = 1'b0;
               w_ffvec_nxt  = '0;
               w_pass_nxt   = 1'b0;
               w_stim_nxt   = '0;
               w_settle_nxt = '0;
               w_busy_nxt   = 1'b1;
               w_state_nxt  = DRIVE;
            end
         end

         DRIVE: begin
            if (r_settle == SETTLE_LAST) begin
               w_state_nxt = CHECK;
            end else begin
               w_settle_nxt = r_settle + SETTLE_ONE;
            end
         end

         CHECK: begin
            if (w_mismatch) begin
               if (r_err != ERR_SAT) begin
                  w_err_nxt = r_err + ERR_ONE;
               end
               if (!r_ffv) begin
                  w_ffv_nxt   = 1'b1;
                  w_ffvec_nxt = r_stim[N_IN-1:0];
               end
            end
            // pass is taken from the updated count so the last vector's verdict is included.
            if (r_stim == LAST_VEC) begin
               w_state_nxt = DONE;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_pass_nxt  = (w_err_nxt == '0);
               w_stim_nxt  = '0;
            end else begin
               w_stim_nxt   = r_stim + STIM_ONE;
               w_settle_nxt = '0;
               w_state_nxt  = DRIVE;
            end
         end

         DONE: begin
            w_state_nxt = IDLE;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_mode   <= '0;
         r_stim   <= '0;
         r_settle <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
         r_err    <= '0;
         r_ffv    <= 1'b0;
         r_ffvec  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_mode   <= w_mode_nxt;
         r_stim   <= w_stim_nxt;
         r_settle <= w_settle_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_pass   <= w_pass_nxt;
         r_err    <= w_err_nxt;
         r_ffv    <= w_ffv_nxt;
         r_ffvec  <= w_ffvec_nxt;
      end
   end

   assign stim_out         = r_stim[N_IN-1:0];
   assign busy             = r_busy;
   assign done             = r_done;
   assign pass             = r_pass;
   assign err_count        = r_err;
   assign first_fail_valid = r_ffv;
   assign first_fail_vec   = r_ffvec;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two instances (N_IN=2/SETTLE=1/ERR_W=8 and N_IN=3/SETTLE=2/ERR_W=2)
// against a cycle-offset model of the sweep, plus hand-computed directed expectations.
module tb_gate_sweep_checker;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic       start_i [2];
   logic [2:0] mode_i  [2];
   int         kind    [2];

   logic [1:0] stim_a;
   logic [2:0] stim_b;
   logic       dut_in_a, dut_in_b;
   logic       busy_o [2];
   logic       done_o [2];
   logic       pass_o [2];
   logic       ffv_o  [2];
   logic [7:0] err_a;
   logic [1:0] err_b;
   logic [1:0] ffvec_a;
   logic [2:0] ffvec_b;

   int NI [2] = '{2, 3};
   int SI [2] = '{1, 2};
   int EW [2] = '{8, 2};

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;
   int cyc    = 0;

   function automatic int popc(int v);
      int c;
      c = 0;
      for (int b = 0; b < 8; b++) c += (v >> b) & 1;
      return c;
   endfunction

   // Expected gate output from the truth-table definition (count of ones).
   function automatic logic gold(int m, int v, int n);
      int p;
      p = popc(v);
      case (m)
         0:       return logic'(p == n);
         1:       return logic'(p > 0);
         2:       return logic'(p != n);
         3:       return logic'(p == 0);
         4:       return logic'(p % 2 == 1);
         5:       return logic'(p % 2 == 0);
         6:       return logic'((v & 1) == 0);
         default: return logic'((v & 1) == 1);
      endcase
   endfunction

   // Gate-under-test: 0 correct NOR, 1 stuck-at-0, 2 stuck-at-1, 3 correct XOR.
   function automatic logic gut(int k, int v);
      case (k)
         0:       return logic'(popc(v) == 0);
         1:       return 1'b0;
         2:       return 1'b1;
         default: return logic'(popc(v) % 2 == 1);
      endcase
   endfunction

   assign dut_in_a = gut(kind[0], int'(stim_a));
   assign dut_in_b = gut(kind[1], int'(stim_b));

   gate_sweep_checker #(.N_IN(2), .SETTLE(1), .ERR_W(8)) u_dut_a (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start_i[0]),
      .mode             (mode_i[0]),
      .stim_out         (stim_a),
      .dut_in           (dut_in_a),
      .busy             (busy_o[0]),
      .done             (done_o[0]),
      .pass             (pass_o[0]),
      .err_count        (err_a),
      .first_fail_valid (ffv_o[0]),
      .first_fail_vec   (ffvec_a)
   );

   gate_sweep_checker #(.N_IN(3), .SETTLE(2), .ERR_W(2)) u_dut_b (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start_i[1]),
      .mode             (mode_i[1]),
      .stim_out         (stim_b),
      .dut_in           (dut_in_b),
      .busy             (busy_o[1]),
      .done             (done_o[1]),
      .pass             (pass_o[1]),
      .err_count        (err_b),
      .first_fail_valid (ffv_o[1]),
      .first_fail_vec   (ffvec_b)
   );

   task automatic check(string name, logic [31:0] act, int exp);
      n_chk++;
      if (act !== 32'(exp)) $display("FAIL %s: got %0d, required %0d", name, act, exp);
      else n_pass++;
   endtask

   // Model: position inside a sweep is just the number of edges since start was accepted.
   bit m_act   [2] = '{1'b0, 1'b0};
   bit m_fresh [2] = '{1'b1, 1'b1};
   int m_j     [2] = '{0, 0};
   int m_mode  [2] = '{0, 0};
   int m_kind  [2] = '{0, 0};

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_act[i]   = 1'b0;
            m_fresh[i] = 1'b1;
            m_j[i]     = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_act[i]) begin
               if (m_j[i] == (1 << NI[i]) * (SI[i] + 1)) m_act[i] = 1'b0;
               else m_j[i]++;
            end else if (start_i[i]) begin
               m_act[i]   = 1'b1;
               m_j[i]     = 0;
               m_mode[i]  = int'(mode_i[i]);
               m_kind[i]  = kind[i];
               m_fresh[i] = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            int n, s, t, jj, nv, cnt, fvec, mx;
            int e_stim, e_err, e_busy, e_done, e_pass, e_ffv;
            n = NI[i]; s = SI[i]; t = (1 << n) * (s + 1); mx = (1 << EW[i]) - 1;
            e_stim = 0; e_err = 0; e_busy = 0; e_done = 0; e_pass = 0; e_ffv = 0; fvec = 0;
            if (!m_fresh[i]) begin
               jj     = m_act[i] ? m_j[i] : t;
               e_busy = (m_act[i] && jj < t) ? 1 : 0;
               e_done = (m_act[i] && jj == t) ? 1 : 0;
               e_stim = (m_act[i] && jj < t) ? jj / (s + 1) : 0;
               nv     = jj / (s + 1);
               cnt    = 0;
               for (int v = 0; v < nv; v++) begin
                  if (gut(m_kind[i], v) != gold(m_mode[i], v, n)) begin
                     if (cnt == 0) fvec = v;
                     cnt++;
                  end
               end
               e_ffv  = (cnt > 0) ? 1 : 0;
               e_err  = (cnt > mx) ? mx : cnt;
               e_pass = (jj == t && cnt == 0) ? 1 : 0;
            end
            check($sformatf("model stim%0d@%0d", i, cyc), (i == 0) ? 32'(stim_a) : 32'(stim_b), e_stim);
            check($sformatf("model busy%0d@%0d", i, cyc), 32'(busy_o[i]), e_busy);
            check($sformatf("model done%0d@%0d", i, cyc), 32'(done_o[i]), e_done);
            check($sformatf("model pass%0d@%0d", i, cyc), 32'(pass_o[i]), e_pass);
            check($sformatf("model err%0d@%0d", i, cyc), (i == 0) ? 32'(err_a) : 32'(err_b), e_err);
            check($sformatf("model ffv%0d@%0d", i, cyc), 32'(ffv_o[i]), e_ffv);
            check($sformatf("model ffvec%0d@%0d", i, cyc), (i == 0) ? 32'(ffvec_a) : 32'(ffvec_b), fvec);
         end
      end
   end

   task automatic do_start(int i, int m, output int c0);
      @(posedge clk);
      #1 start_i[i] = 1'b1; mode_i[i] = 3'(m);
      @(posedge clk);
      #1 c0 = cyc; start_i[i] = 1'b0;
   endtask

   // lat = index of the cycle carrying done, counting the start-sampling cycle as 0.
   task automatic wait_done(int i, int c0, output int lat);
      int guard;
      guard = 0;
      lat   = -1;
      while (guard < 200) begin
         @(negedge clk);
         if (done_o[i] === 1'b1) begin
            lat = cyc - c0 + 1;
            break;
         end
         guard++;
      end
   endtask

   int exp_seq [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

   initial begin
      int c0, lat, guard, ndone;
      int seq [8];
      for (int i = 0; i < 2; i++) begin
         start_i[i] = 1'b0;
         mode_i[i]  = 3'd0;
         kind[i]    = 0;
      end
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      #2;
      check("reset busy", 32'(busy_o[0]), 0);
      check("reset stim", 32'(stim_a), 0);
      check("reset err", 32'(err_a), 0);
      check("reset ffv", 32'(ffv_o[0]), 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      // Correct NOR, mode NOR.
      kind[0] = 0;
      do_start(0, 3, c0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         seq[k] = int'(stim_a);
      end
      for (int k = 0; k < 8; k++) check($sformatf("nor stim seq %0d", k), 32'(seq[k]), exp_seq[k]);
      wait_done(0, c0, lat);
      check("nor latency", 32'(lat), 9);
      check("nor pass", 32'(pass_o[0]), 1);
      check("nor err", 32'(err_a), 0);
      check("nor ffv", 32'(ffv_o[0]), 0);

      // Correct NOR checked as OR: every vector disagrees.
      do_start(0, 1, c0);
      wait_done(0, c0, lat);
      check("or err", 32'(err_a), 4);
      check("or pass", 32'(pass_o[0]), 0);
      check("or ffvec", 32'(ffvec_a), 0);
      check("or ffv", 32'(ffv_o[0]), 1);

      kind[0] = 1;
      do_start(0, 3, c0);
      wait_done(0, c0, lat);
      check("stuck0 err", 32'(err_a), 1);
      check("stuck0 ffvec", 32'(ffvec_a), 0);

      kind[0] = 2;
      do_start(0, 3, c0);
      wait_done(0, c0, lat);
      check("stuck1 err", 32'(err_a), 3);
      check("stuck1 ffvec", 32'(ffvec_a), 1);

      // 3-input XOR checked as XNOR: 8 mismatches saturate a 2-bit counter.
      kind[1] = 3;
      do_start(1, 5, c0);
      wait_done(1, c0, lat);
      check("xnor latency", 32'(lat), 25);
      check("xnor err sat", 32'(err_b), 3);
      check("xnor pass", 32'(pass_o[1]), 0);
      check("xnor ffvec", 32'(ffvec_b), 0);
      check("xnor ffv", 32'(ffv_o[1]), 1);

      // Abort during the DRIVE of vector 2'b10.
      kind[0] = 0;
      do_start(0, 1, c0);
      guard = 0;
      while (guard < 50 && !(stim_a == 2'd2 && busy_o[0] === 1'b1)) begin
         @(negedge clk);
         guard++;
      end
      check("abort reached v2", 32'(guard < 50), 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort busy", 32'(busy_o[0]), 0);
      check("abort stim", 32'(stim_a), 0);
      check("abort err", 32'(err_a), 0);
      check("abort ffv", 32'(ffv_o[0]), 0);
      check("abort err b", 32'(err_b), 0);
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done_o[0] === 1'b1) ndone++;
      end
      check("abort no done", 32'(ndone), 0);
      do_start(0, 3, c0);
      wait_done(0, c0, lat);
      check("post-abort latency", 32'(lat), 9);
      check("post-abort pass", 32'(pass_o[0]), 1);

      // Re-pulsed start and mode change mid-sweep are ignored.
      do_start(0, 3, c0);
      repeat (3) @(posedge clk);
      #1 start_i[0] = 1'b1; mode_i[0] = 3'd1;
      @(posedge clk);
      #1 start_i[0] = 1'b0;
      wait_done(0, c0, lat);
      check("repulse latency", 32'(lat), 9);
      check("repulse err", 32'(err_a), 0);
      check("repulse pass", 32'(pass_o[0]), 1);

      // start held high restarts in the cycle after done.
      @(posedge clk);
      #1 start_i[0] = 1'b1; mode_i[0] = 3'd3;
      @(posedge clk);
      #1 c0 = cyc;
      wait_done(0, c0, lat);
      check("held first latency", 32'(lat), 9);
      wait_done(0, c0, lat);
      start_i[0] = 1'b0;
      check("held second latency", 32'(lat), 19);

      repeat (6) @(negedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Parametrised exhaustive tester for N-input combinational gates. On `start` it drives every input combination, 0 to 2^N_IN-1 in ascending order, onto an external gate-under-test. For each vector it waits a programmable settle time, samples the gate's output and compares it with an internal golden model for the selected gate function. Mismatches are counted and the first failing vector is recorded. It generalises the hand-written per-gate stimulus sequences into one reusable, mode-selectable, self-checking block that sits between the stimulus side of a design and any 1-bit gate instance.

Parameters:
- N_IN, 2, number of gate inputs (1..8); the sweep length is 2^N_IN vectors.
- SETTLE, 1, number of cycles each vector is held before sampling (must be ≥1).
- ERR_W, 8, width of the mismatch counter; the counter saturates.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a sweep; sampled only in IDLE.
- mode  in  3  gate function; latched at start. 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(bit0), 7 BUF(bit0).
- stim_out  out  N_IN  vector driven to the gate-under-test.
- dut_in  in  1  gate-under-test output.
- busy  out  1  high from the cycle after start is accepted until DONE is reached.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  1 if err_count==0 at completion; held until the next start.
- err_count  out  ERR_W  mismatches in the last or current sweep; saturates at all-ones.
- first_fail_valid  out  1  1 once any mismatch has been recorded in this sweep.
- first_fail_vec  out  N_IN  stimulus of the first mismatch; held.

Behaviour:

Reset (async assert, sync release). On reset:
- state=IDLE.
- stim_out=0, busy=0, done=0, pass=0, err_count=0.
- first_fail_valid=0, first_fail_vec=0.
- A reset asserted mid-sweep aborts the sweep immediately; no done pulse is produced.

IDLE:
- Outputs hold their last results.
- start=1 does the following: latch mode, clear err_count, clear first_fail_valid/first_fail_vec, clear pass, set stim_out=0 and settle_cnt=0. Then go to DRIVE with busy=1 on the next cycle.

DRIVE:
- Hold stim_out; increment settle_cnt.
- When settle_cnt==SETTLE-1, go to CHECK.

CHECK (1 cycle):
- Compare dut_in against golden(mode_q, stim_out).
- On a mismatch: if err_count is not all-ones, increment it. If first_fail_valid==0, load first_fail_vec=stim_out and set first_fail_valid=1.
- If stim_out==2^N_IN-1, go to DONE. Otherwise stim_out+=1, settle_cnt=0, and go to DRIVE.

DONE (1 cycle):
- done=1, busy=0, pass=(err_count==0). The mismatch from the final CHECK is already included in err_count.
- stim_out returns to 0. Go to IDLE.

Timing:
- Each vector occupies SETTLE+1 cycles.
- The done pulse occurs exactly 2^N_IN*(SETTLE+1)+1 cycles after the cycle in which start was sampled.
- There is no combinational path from dut_in to any output.

Boundary rules:
- start is ignored while busy or in DONE; it is not queued.
- start held high continuously restarts a sweep in the cycle after done.
- mode changes during a sweep have no effect.
- Golden model for N_IN=1: AND/OR/XOR/BUF return bit0; NAND/NOR/XNOR/NOT return ~bit0.
- The stimulus counter is N_IN+1 bits internally so the terminal vector is detected without wrap-around. stim_out never wraps to 0 before CHECK of the last vector.

Decomposition:
- Shared package gate_pkg holds the mode encodings (MODE_AND..MODE_BUF) and the FSM state encodings (IDLE, DRIVE, CHECK, DONE).
- One natural sub-module, gate_golden: purely combinational, parameter N_IN, inputs mode[2:0] and vec[N_IN-1:0], output y. It is reusable by benches as a scoreboard.

Test Plan:
- Correct NOR, N_IN=2, SETTLE=1, mode=3, start pulse → stim_out sequence 00,01,10,11, each held 2 cycles; done 9 cycles after start; pass=1, err_count=0, first_fail_valid=0.
- Correct NOR, mode=1 (OR) → err_count=4, pass=0, first_fail_vec=00, first_fail_valid=1.
- DUT stuck-at-0, mode=3 → err_count=1, first_fail_vec=00; DUT stuck-at-1, mode=3 → err_count=3, first_fail_vec=01.
- N_IN=3, ERR_W=2, correct XOR DUT, mode=5 (XNOR) → 8 mismatches; err_count saturates at 3, pass=0, first_fail_vec=000.
- Reset asserted during the vector-10 DRIVE → all outputs return to their reset values asynchronously; no done pulse. A new start then produces a full, clean sweep.
- start re-pulsed while busy and mode toggled mid-sweep → no restart, sweep length unchanged, results match the mode latched at the original start.
